// File: rtl/uart_dpram_ctrl.sv
// -----------------------------------------------------------------------------
// uart_dpram_ctrl
//
// Sequencer for the dual-port RAM in the UART loopback path.
//  - Write side: every accepted Rx_done writes Rx_data to RAM port A at the
//    next free address. The address never wraps, and the buffer saturates
//    when it is full.
//  - Read side: a Key_flag with a non-empty buffer starts a dump. Every byte
//    stored at that moment is read through port B and handed to the UART
//    transmitter. Each byte waits for the transmitter's Tx_done.
//
// Optional build macro: UART_DPRAM_CTRL_AUTOCLR_EN
//   When it is defined, received bytes are dropped while a dump is busy, and
//   the buffer empties (Count -> 0) when a dump completes.
//
// Parameters:
//   ADDR_W  RAM address width, depth = 2**ADDR_W
//   RD_LAT  port-B latency from Ram_rdaddr to valid Ram_q (1..3)
//
// Ports:
//   Clk, Rst                          clock, async active-high reset
//   Rx_done, Rx_data                  received byte strobe and data
//   Key_flag                          debounced key press pulse
//   Ram_wren/Ram_wraddr/Ram_wrdata    RAM port A write
//   Ram_rdaddr, Ram_q                 RAM port B read
//   Tx_en, Tx_data, Tx_done           transmitter handshake
//   Count, Full                       stored byte count, buffer full
//   Busy, Dump_done                   dump in progress, dump finished pulse
// -----------------------------------------------------------------------------
module uart_dpram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx_done,
    input  logic [7:0]        Rx_data,
    input  logic              Key_flag,
    output logic              Ram_wren,
    output logic [ADDR_W-1:0] Ram_wraddr,
    output logic [7:0]        Ram_wrdata,
    output logic [ADDR_W-1:0] Ram_rdaddr,
    input  logic [7:0]        Ram_q,
    output logic              Tx_en,
    output logic [7:0]        Tx_data,
    input  logic              Tx_done,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Busy,
    output logic              Dump_done
);

    localparam logic [ADDR_W:0] ZERO_W   = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] ONE_W    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_M1 = {1'b0, {ADDR_W{1'b1}}};
    // WAIT covers RD_LAT-1 cycles; the counter runs 0..RD_LAT-2.
    localparam logic [1:0]      WAIT_LAST = (RD_LAT > 2) ? 2'(RD_LAT - 2) : 2'd0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   len_q;
    logic [1:0]        wait_cnt_q;
    logic              tx_en_q;
    logic [7:0]        tx_data_q;
    logic              dump_done_q;

    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [7:0]        wrdata_q, wrdata_d;

    logic [ADDR_W:0]   next_ptr_s;
    logic              last_s;
    logic              accept_s;
    logic              clear_s;

    // The byte in HOLD is the last one when rd_ptr+1 reaches the latched length.
    assign next_ptr_s = {1'b0, rd_ptr_q} + ONE_W;
    assign last_s     = (next_ptr_s >= len_q);

`ifdef UART_DPRAM_CTRL_AUTOCLR_EN
    // The clear fires on the edge that raises Dump_done. A byte that arrives in
    // that cycle is already being dropped because the dump is still busy.
    assign accept_s = Rx_done && !full_q && (state_q == IDLE);
    assign clear_s  = (state_q == HOLD) && Tx_done && last_s;
`else
    assign accept_s = Rx_done && !full_q;
    assign clear_s  = 1'b0;
`endif

    // Write-side next state: one-cycle write strobe, and the count is also the write pointer.
    always_comb begin
        count_d  = count_q;
        full_d   = full_q;
        wren_d   = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        if (clear_s) begin
            count_d = ZERO_W;
            full_d  = 1'b0;
        end else if (accept_s) begin
            wren_d   = 1'b1;
            wraddr_d = count_q[ADDR_W-1:0];
            wrdata_d = Rx_data;
            count_d  = count_q + ONE_W;
            full_d   = (count_q == DEPTH_M1);
        end else begin
            count_d = count_q;
        end
    end

    // Write-side registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q  <= ZERO_W;
            full_q   <= 1'b0;
            wren_q   <= 1'b0;
            wraddr_q <= {ADDR_W{1'b0}};
            wrdata_q <= 8'h00;
        end else begin
            count_q  <= count_d;
            full_q   <= full_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
        end
    end

    // Dump sequencer: the address is registered when ADDR is entered, so it
    // is on the RAM during ADDR, and it holds until the next byte.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= {ADDR_W{1'b0}};
            len_q       <= ZERO_W;
            wait_cnt_q  <= 2'd0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            dump_done_q <= 1'b0;
        end else begin
            tx_en_q     <= 1'b0;
            dump_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Key_flag && (count_q != ZERO_W)) begin
                        len_q    <= count_q;
                        rd_ptr_q <= {ADDR_W{1'b0}};
                        state_q  <= ADDR;
                    end
                end
                ADDR: begin
                    wait_cnt_q <= 2'd0;
                    if (RD_LAT == 1) begin
                        tx_en_q <= 1'b1;
                        state_q <= SEND;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        tx_en_q <= 1'b1;
                        state_q <= SEND;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                SEND: begin
                    // Tx_data keeps this byte until the next SEND.
                    tx_data_q <= Ram_q;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    if (Tx_done) begin
                        if (!last_s) begin
                            rd_ptr_q <= next_ptr_s[ADDR_W-1:0];
                            state_q  <= ADDR;
                        end else begin
                            dump_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Ram_wren   = wren_q;
    assign Ram_wraddr = wraddr_q;
    assign Ram_wrdata = wrdata_q;
    assign Ram_rdaddr = rd_ptr_q;
    assign Count      = count_q;
    assign Full       = full_q;
    assign Busy       = (state_q != IDLE);
    assign Tx_en      = tx_en_q;
    assign Dump_done  = dump_done_q;
    // Ram_q is valid only in the cycle where Tx_en is high. It is passed
    // through in that cycle and held from the register after it.
    assign Tx_data    = (state_q == SEND) ? Ram_q : tx_data_q;

endmodule

// File: tb/tb_uart_dpram_ctrl.sv
module tb_uart_dpram_ctrl;

    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 256;

    logic              Clk;
    logic              Rst;
    logic              Rx_done;
    logic [7:0]        Rx_data;
    logic              Key_flag;
    logic              Ram_wren;
    logic [ADDR_W-1:0] Ram_wraddr;
    logic [7:0]        Ram_wrdata;
    logic [ADDR_W-1:0] Ram_rdaddr;
    logic [7:0]        Ram_q;
    logic              Tx_en;
    logic [7:0]        Tx_data;
    logic              Tx_done;
    logic [ADDR_W:0]   Count;
    logic              Full;
    logic              Busy;
    logic              Dump_done;

    uart_dpram_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Rx_done(Rx_done), .Rx_data(Rx_data),
        .Key_flag(Key_flag), .Ram_wren(Ram_wren), .Ram_wraddr(Ram_wraddr),
        .Ram_wrdata(Ram_wrdata), .Ram_rdaddr(Ram_rdaddr), .Ram_q(Ram_q),
        .Tx_en(Tx_en), .Tx_data(Tx_data), .Tx_done(Tx_done), .Count(Count),
        .Full(Full), .Busy(Busy), .Dump_done(Dump_done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // RAM model: port A write, port B read with RD_LAT cycles of address pipeline.
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_pipe [RD_LAT];
    always @(posedge Clk) begin
        if (Ram_wren) mem[Ram_wraddr] <= Ram_wrdata;
        rd_pipe[0] <= Ram_rdaddr;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign Ram_q = mem[rd_pipe[RD_LAT-1]];

    // Cycle counter, transmitter model (Tx_done 100 cycles after Tx_en) and logs.
    int         cyc;
    int         tx_timer;
    logic [7:0] tx_log [$];
    int         tx_cyc [$];
    int         dd_cnt;
    int         dd_cyc;
    initial begin
        cyc = 0; tx_timer = 0; dd_cnt = 0; dd_cyc = -1; Tx_done = 1'b0;
        forever begin
            @(posedge Clk); #1;
            cyc++;
            Tx_done = 1'b0;
            if (tx_timer > 0) begin
                tx_timer--;
                if (tx_timer == 0) Tx_done = 1'b1;
            end
            if (Tx_en === 1'b1) begin
                tx_log.push_back(Tx_data);
                tx_cyc.push_back(cyc);
                tx_timer = 100;
            end
            if (Dump_done === 1'b1) begin
                dd_cnt++;
                dd_cyc = cyc;
            end
        end
    end

    int         total;
    int         bad;
    logic [7:0] exp_q [$];
    logic [7:0] snap [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wren"}, Ram_wren, 0);
        chk({tag, "_wraddr"}, Ram_wraddr, 0);
        chk({tag, "_wrdata"}, Ram_wrdata, 0);
        chk({tag, "_rdaddr"}, Ram_rdaddr, 0);
        chk({tag, "_tx_en"}, Tx_en, 0);
        chk({tag, "_tx_data"}, Tx_data, 0);
        chk({tag, "_count"}, Count, 0);
        chk({tag, "_full"}, Full, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_dump_done"}, Dump_done, 0);
    endtask

    // One received byte; the reference decides acceptance from buffer size and dump state.
    task automatic do_rx(input logic [7:0] b, input bit in_dump);
        bit acc;
        acc = (exp_q.size() < DEPTH);
`ifdef UART_DPRAM_CTRL_AUTOCLR_EN
        if (in_dump) acc = 1'b0;
`endif
        Rx_data = b; Rx_done = 1'b1;
        @(negedge Clk);
        Rx_done = 1'b0;
        chk("wren", Ram_wren, acc);
        if (acc) begin
            chk("wraddr", Ram_wraddr, exp_q.size());
            chk("wrdata", Ram_wrdata, b);
            exp_q.push_back(b);
        end
        chk("count", Count, exp_q.size());
        chk("full", Full, exp_q.size() == DEPTH);
    endtask

    task automatic key_pulse(output int kcyc);
        Key_flag = 1'b1; kcyc = cyc;
        @(negedge Clk);
        Key_flag = 1'b0;
    endtask

    task automatic wait_dd(input int start_dd, input int budget);
        int n;
        n = 0;
        while (dd_cnt == start_dd && n < budget) begin
            @(negedge Clk);
            n++;
        end
        chk("dump_done_seen", dd_cnt, start_dd + 1);
    endtask

    // Compare the bytes sent since 'base' against the snapshot and the expected cadence.
    task automatic check_dump(input int base, input int kcyc, input int n);
        int exp_c;
        chk("tx_count", tx_log.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < tx_log.size()) begin
                chk($sformatf("tx_data[%0d]", i), tx_log[base+i], snap[i]);
                if (i == 0) exp_c = kcyc + 1 + RD_LAT;
                else        exp_c = tx_cyc[base+i-1] + 101 + RD_LAT;
                chk($sformatf("tx_cyc[%0d]", i), tx_cyc[base+i], exp_c);
            end
        end
        if (n > 0 && tx_log.size() >= base + n)
            chk("dd_cyc", dd_cyc, tx_cyc[base+n-1] + 101);
    endtask

    initial begin
        int kcyc, base, dd0, n;
        total = 0; bad = 0;
        Rst = 1'b1; Rx_done = 1'b0; Rx_data = 8'h00; Key_flag = 1'b0;
        repeat (3) @(negedge Clk);
        chk_all_zero("reset");
        Rst = 1'b0;
        @(negedge Clk);

        // Key press on an empty buffer is ignored.
        key_pulse(kcyc);
        chk("empty_key_busy", Busy, 0);
        repeat (20) @(negedge Clk);
        chk("empty_key_tx", tx_log.size(), 0);
        chk("empty_key_dd", dd_cnt, 0);

        // Four writes with random gaps.
        do_rx(8'h5A, 1'b0); repeat ($urandom_range(0, 3)) @(negedge Clk);
        do_rx(8'hAA, 1'b0); repeat ($urandom_range(0, 3)) @(negedge Clk);
        do_rx(8'h55, 1'b0); repeat ($urandom_range(0, 3)) @(negedge Clk);
        do_rx(8'h77, 1'b0);
        @(negedge Clk);
        chk("wren_idle", Ram_wren, 0);

        // 4-byte dump with an ignored second key press and a byte arriving mid-dump.
        snap = exp_q; base = tx_log.size(); dd0 = dd_cnt;
        key_pulse(kcyc);
        chk("dump_busy", Busy, 1);
        chk("dump_rdaddr0", Ram_rdaddr, 0);
        repeat (48) @(negedge Clk);
        Key_flag = 1'b1; @(negedge Clk); Key_flag = 1'b0;
        repeat (70) @(negedge Clk);
        do_rx(8'h33, 1'b1);
        wait_dd(dd0, 3000);
        chk("dd_busy", Busy, 0);
        chk("dd_pulse", Dump_done, 1);
        check_dump(base, kcyc, snap.size());
`ifdef UART_DPRAM_CTRL_AUTOCLR_EN
        exp_q.delete();
`endif
        chk("count_after_dump", Count, exp_q.size());

        // A key in the Dump_done cycle restarts a dump of the current contents.
        snap = exp_q; base = tx_log.size(); dd0 = dd_cnt;
        key_pulse(kcyc);
        chk("restart_busy", Busy, snap.size() != 0);
        if (snap.size() != 0) begin
            wait_dd(dd0, 3000);
            check_dump(base, kcyc, snap.size());
            chk("restart_last", tx_log[tx_log.size()-1], 8'h33);
        end
`ifdef UART_DPRAM_CTRL_AUTOCLR_EN
        exp_q.delete();
`endif

        // Reset during HOLD of byte 2 aborts the dump.
        for (int i = 0; i < 3; i++) do_rx(8'($urandom), 1'b0);
        snap = exp_q; base = tx_log.size(); dd0 = dd_cnt;
        key_pulse(kcyc);
        n = 0;
        while (tx_log.size() < base + 2 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        chk("abort_reach_byte2", tx_log.size() - base, 2);
        repeat (10) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        chk_all_zero("abort");
        Rst = 1'b0;
        exp_q.delete();
        repeat (300) @(negedge Clk);
        chk("abort_no_tx", tx_log.size() - base, 2);
        chk("abort_no_dd", dd_cnt, dd0);
        chk("abort_byte0", tx_log[base], snap[0]);
        chk("abort_byte1", tx_log[base+1], snap[1]);

        // Fill: 260 back-to-back writes, the last four are dropped.
        for (int i = 0; i < 260; i++) do_rx(8'($urandom), 1'b0);
        chk("fill_count", Count, DEPTH);
        chk("fill_full", Full, 1);

        // Dump of a full buffer.
        snap = exp_q; base = tx_log.size(); dd0 = dd_cnt;
        key_pulse(kcyc);
        wait_dd(dd0, 30000);
        check_dump(base, kcyc, DEPTH);
`ifdef UART_DPRAM_CTRL_AUTOCLR_EN
        exp_q.delete();
`endif
        chk("final_count", Count, exp_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
